// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one synchronous memory port among NUM_MASTERS requesters (round-robin; fixed priority when ARB_FIXED_PRIORITY_EN is defined).
// Latency: write ack 2 cycles after the IDLE cycle that samples req, read ack 2+READ_LAT cycles after it.
// Backpressure: req is a level held until ack; one transaction in flight, losing requesters simply wait in IDLE.
module cpu_mem_arbiter #(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_MASTERS = 2,
  parameter int READ_LAT    = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS-1:0]            we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_MASTERS*WIDTH-1:0]      wdata,
  output logic [NUM_MASTERS-1:0]            ack,
  output logic [WIDTH-1:0]                  rdata,
  output logic                              busy,
  input  logic [WIDTH-1:0]                  memdata,
  output logic                              memwrite,
  output logic [ADDR_WIDTH-1:0]             adr,
  output logic [WIDTH-1:0]                  memOut
);

  localparam int         IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [2:0] WAIT_LAST = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                  state_q, state_d;
  logic                    win_vld;
  logic [IDX_W-1:0]        win_idx;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [WIDTH-1:0]        sel_wdata;

  logic [IDX_W-1:0]        win_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]        wdata_q;
  logic [2:0]              wait_cnt_q;
  logic [WIDTH-1:0]        rdata_q;

`ifdef ARB_FIXED_PRIORITY_EN
  // Fixed priority: the lowest requesting index wins (scan high to low, last hit sticks).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] cand;

  // Round-robin: walk offsets N..1 from last_grant so the nearest requester after it wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant_q) + i) % NUM_MASTERS);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Remember the most recent grant; reset value makes master 0 first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
    end else if (state_q == IDLE && win_vld) begin
      last_grant_q <= win_idx;
    end
  end
`endif

  // Pick the winner's write flag, address and data out of the flattened buses.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register; reset aborts any transaction without an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the per-state strobes (ack, memwrite, busy).
  always_comb begin
    state_d  = state_q;
    ack      = '0;
    memwrite = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (win_vld) state_d = ISSUE;
      end
      ISSUE: begin
        memwrite = we_q;
        state_d  = we_q ? ACK : WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = ACK;
      end
      ACK: begin
        ack     = NUM_MASTERS'(1) << win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request, count read wait cycles and capture read data on the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      if (state_q == IDLE && win_vld) begin
        win_q   <= win_idx;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + 3'd1;
      end
      if (state_q == WAIT && wait_cnt_q == WAIT_LAST) begin
        rdata_q <= memdata;
      end
    end
  end

  // The latched request only changes on a grant, so adr/memOut hold between transactions.
  assign adr    = addr_q;
  assign memOut = wdata_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
`timescale 1ns/1ps
module tb_cpu_mem_arbiter;
  localparam int N    = 2;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, we;
  logic [AW-1:0] a_m [N];
  logic [DW-1:0] d_m [N];
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  ack;
  logic [DW-1:0] rdata, memdata, memOut;
  logic [AW-1:0] adr;
  logic          busy, memwrite;

  logic [N-1:0]  req3, we3, ack3;
  logic [N*AW-1:0] addr3;
  logic [N*DW-1:0] wdata3;
  logic [DW-1:0] rdata3, memdata3, memOut3;
  logic [AW-1:0] adr3;
  logic          busy3, memwrite3;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign addr[g*AW +: AW]  = a_m[g];
    assign wdata[g*DW +: DW] = d_m[g];
  end

  cpu_mem_arbiter #(.WIDTH(DW), .ADDR_WIDTH(AW), .NUM_MASTERS(N), .READ_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .memdata(memdata), .memwrite(memwrite),
    .adr(adr), .memOut(memOut));

  cpu_mem_arbiter #(.WIDTH(DW), .ADDR_WIDTH(AW), .NUM_MASTERS(N), .READ_LAT(LAT3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .ack(ack3), .rdata(rdata3), .busy(busy3), .memdata(memdata3), .memwrite(memwrite3),
    .adr(adr3), .memOut(memOut3));

  function automatic logic [DW-1:0] init_val(input int i);
    logic [DW-1:0] v;
    v = (i == 0) ? 16'hBEEF : (16'(i) * 16'h1111) ^ 16'h5A5A;
    return v;
  endfunction

  // Memory environment: 16 words, synchronous read, reloaded while reset is low.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (memwrite) begin
      mem[adr[3:0]] <= memOut;
    end
    memdata <= mem[adr[3:0]];
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int k);
    logic [N-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  // Transaction-level reference: one transaction at a time, ack cycle = grant + 2 (+LAT for reads).
  logic          m_act;
  int            m_grant, m_ack, m_win, m_last;
  logic          m_we;
  logic [AW-1:0] m_addr, m_adr_last;
  logic [DW-1:0] m_wdata, m_rval, m_out_last, m_rdata_last;
  logic [DW-1:0] m_mem [16];
  logic [N-1:0]  e_ack;
  logic          e_busy, e_mw;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_out, e_rdata;

  task automatic model_step();
    int w;
    w = -1;
    if (!reset) begin
      m_act = 1'b0; m_last = N - 1;
      m_adr_last = '0; m_out_last = '0; m_rdata_last = '0;
      for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
      e_ack = '0; e_busy = 1'b0; e_mw = 1'b0; e_adr = '0; e_out = '0; e_rdata = '0;
    end else begin
      if (m_act && cyc > m_ack) m_act = 1'b0;
      if (m_act && cyc == m_ack && !m_we) m_rdata_last = m_rval;
      e_busy  = m_act;
      e_ack   = (m_act && cyc == m_ack) ? (N'(1) << m_win) : '0;
      e_mw    = m_act && (cyc == m_grant + 1) && m_we;
      e_adr   = m_adr_last;
      e_out   = m_out_last;
      e_rdata = m_rdata_last;
      if (!m_act && req != '0) begin
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < N; k++) begin
          if (bit_of(req, k)) begin w = k; break; end
        end
`else
        for (int d = 1; d <= N; d++) begin
          if (bit_of(req, (m_last + d) % N)) begin w = (m_last + d) % N; break; end
        end
`endif
        m_act = 1'b1; m_grant = cyc; m_win = w; m_last = w;
        m_we = bit_of(we, w); m_addr = a_m[w]; m_wdata = d_m[w];
        m_ack = cyc + 2 + (m_we ? 0 : LAT);
        m_adr_last = m_addr; m_out_last = m_wdata;
        if (m_we) m_mem[m_addr[3:0]] = m_wdata;
        else      m_rval = m_mem[m_addr[3:0]];
      end
    end
  endtask

  int            n_ack, n_mw, n_ack3, last_ack_cyc, ack3_cyc;
  logic [N-1:0]  last_ack_vec, ack3_vec;
  logic [DW-1:0] last_rdata, ack3_rd, mw_out;
  logic [AW-1:0] mw_adr;
  logic [N-1:0]  ack_log [$];

  // One clock: predict, compare on the falling edge, then step to 1ns after the next rising edge.
  task automatic tick();
    model_step();
    @(negedge clk);
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("memwrite", 32'(memwrite), 32'(e_mw));
    chk("adr", 32'(adr), 32'(e_adr));
    chk("memOut", 32'(memOut), 32'(e_out));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    if (ack != '0) begin
      n_ack++; last_ack_cyc = cyc; last_ack_vec = ack; last_rdata = rdata;
      ack_log.push_back(ack);
    end
    if (memwrite) begin n_mw++; mw_adr = adr; mw_out = memOut; end
    if (ack3 != '0) begin n_ack3++; ack3_cyc = cyc; ack3_vec = ack3; ack3_rd = rdata3; end
    @(posedge clk); #1;
    cyc++;
    memdata3 = 16'hA000 + cyc[15:0];
  endtask

  task automatic run_until_ack(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_ack > 0) begin req = '0; break; end
    end
  endtask

  int s;
  logic [N-1:0]  pend;
  logic [N-1:0]  exp_g;
  logic [DW-1:0] e3;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req = '0; we = '0;
    for (int i = 0; i < N; i++) begin a_m[i] = '0; d_m[i] = '0; end
    req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0; memdata3 = '0;
    n_ack = 0; n_mw = 0; n_ack3 = 0;
    @(posedge clk); #1;
    cyc = 0;
    repeat (3) tick();
    reset = 1'b1;

    // Contention: both held high; grants alternate (or master 0 always under fixed priority).
    ack_log.delete();
    req = 2'b11; we = 2'b10; a_m[0] = 16'h0100; a_m[1] = 16'h0105; d_m[1] = 16'h7777;
    for (int i = 0; i < 40 && ack_log.size() < 4; i++) tick();
    req = '0;
    chk("rr_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("rr_grant", (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hFFFF_FFFF, 32'(exp_g));
    end
    repeat (8) tick();

    // Single read of 0x0010 holding 0xBEEF.
    n_ack = 0; req = 2'b01; we = 2'b00; a_m[0] = 16'h0010; s = cyc;
    run_until_ack(12);
    chk("rd_lat", 32'(last_ack_cyc - s), 32'd3);
    chk("rd_vec", 32'(last_ack_vec), 32'h1);
    chk("rd_data", 32'(last_rdata), 32'hBEEF);
    repeat (3) tick();

    // Single write 0x1234 -> 0x0020 from master 1.
    n_ack = 0; n_mw = 0; req = 2'b10; we = 2'b10; a_m[1] = 16'h0020; d_m[1] = 16'h1234; s = cyc;
    run_until_ack(12);
    repeat (4) tick();
    chk("wr_lat", 32'(last_ack_cyc - s), 32'd2);
    chk("wr_vec", 32'(last_ack_vec), 32'h2);
    chk("wr_pulses", 32'(n_mw), 32'd1);
    chk("wr_adr", 32'(mw_adr), 32'h0020);
    chk("wr_out", 32'(mw_out), 32'h1234);

    // Requester drops req during ISSUE: one ack, nothing further.
    n_ack = 0; req = 2'b01; we = 2'b00; a_m[0] = 16'h0003;
    tick();
    req = '0;
    repeat (8) tick();
    chk("drop_acks", 32'(n_ack), 32'd1);
    chk("drop_idle", 32'(busy), 32'd0);

    // Reset in WAIT: abort without ack, then a fresh write completes.
    n_ack = 0; req = 2'b10; we = 2'b00; a_m[1] = 16'h0009;
    tick(); tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0; #1;
    chk("rst_mw", 32'(memwrite), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    req = '0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_noack", 32'(n_ack), 32'd0);
    n_ack = 0; req = 2'b10; we = 2'b10; a_m[1] = 16'h0044; d_m[1] = 16'hCAFE; s = cyc;
    run_until_ack(12);
    chk("post_rst_lat", 32'(last_ack_cyc - s), 32'd2);
    chk("post_rst_vec", 32'(last_ack_vec), 32'h2);
    repeat (3) tick();

    // READ_LAT=3 instance: ack 5 cycles after sample, data as presented 3 cycles after ISSUE.
    n_ack3 = 0; req3 = 2'b01; we3 = 2'b00; addr3 = 32'h0000_0007; s = cyc;
    tick();
    req3 = '0;
    repeat (8) tick();
    e3 = 16'hA000 + 16'(s + 4);
    chk("l3_acks", 32'(n_ack3), 32'd1);
    chk("l3_lat", 32'(ack3_cyc - s), 32'd5);
    chk("l3_vec", 32'(ack3_vec), 32'h1);
    chk("l3_data", 32'(ack3_rd), 32'(e3));

    // Randomized traffic against the reference model.
    pend = '0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if (m_act && m_win == k && m_ack == cyc - 1) begin
          pend[k] = 1'b0; req[k] = 1'b0;
        end else if (pend[k] && m_act && m_win == k && cyc > m_grant && $urandom_range(7) == 0) begin
          req[k] = 1'b0;
        end
        if (!pend[k] && $urandom_range(3) == 0) begin
          pend[k] = 1'b1; req[k] = 1'b1;
          we[k]  = 1'($urandom_range(1));
          a_m[k] = 16'($urandom);
          d_m[k] = 16'($urandom);
        end
      end
      tick();
    end
    req = '0;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: address width.
REQ-003 SHALL have parameter NUM_MASTERS, default 2, legal range 1..8: requester channel count.
REQ-004 SHALL have parameter READ_LAT, default 1, legal range 1..4: memory read latency in cycles.
REQ-005 SHALL have port clk, input, 1: single clock; all state on the rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req, input, NUM_MASTERS: per-master request, level, held until ack.
REQ-008 SHALL have port we, input, NUM_MASTERS: per-master write flag; 1 = write, 0 = read.
REQ-009 SHALL have port addr, input, NUM_MASTERS*ADDR_WIDTH: flattened addresses; master k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port wdata, input, NUM_MASTERS*WIDTH: flattened write data, packed the same way.
REQ-011 SHALL have port ack, output, NUM_MASTERS: one-cycle completion pulse to the granted master.
REQ-012 SHALL have port rdata, output, WIDTH: registered read data, valid while ack is high for a read.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port memdata, input, WIDTH: synchronous memory read data.
REQ-015 SHALL have port memwrite, output, 1: memory write enable.
REQ-016 SHALL have port adr, output, ADDR_WIDTH: memory address.
REQ-017 SHALL have port memOut, output, WIDTH: memory write data.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK.
REQ-019 In IDLE with any req bit high, SHALL select a winner, latch its we/addr/wdata and index, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 In ISSUE, SHALL drive adr/memOut from the latched values and memwrite = latched we for exactly one cycle.
REQ-021 After ISSUE, a write SHALL go directly to ACK; a read SHALL go to WAIT.
REQ-022 A read SHALL remain in WAIT for READ_LAT cycles and capture memdata into rdata at the end of the last WAIT cycle, then go to ACK.
REQ-023 Latency from the IDLE cycle t that samples req: write ack in cycle t+2; read ack in cycle t+2+READ_LAT.
REQ-024 In ACK, SHALL assert only ack[winner] for one cycle, then return to IDLE.
REQ-025 Arbitration SHALL be round-robin: the search starts at index (last_grant+1) mod NUM_MASTERS; last_grant updates on each grant.
REQ-026 With NUM_MASTERS=1, master 0 SHALL always win.
REQ-027 A req bit dropping mid-transaction SHALL be ignored; the transaction completes and ack is still pulsed.
REQ-028 A req still high in the IDLE cycle after ACK SHALL be treated as a new request.
REQ-029 Outside ISSUE, memwrite SHALL be 0; adr/memOut SHALL hold their last driven values.
REQ-030 rdata SHALL hold its value until the next read capture.

Reset
REQ-031 On reset low, the block SHALL immediately (asynchronously) enter IDLE and abort any transaction, with no ack issued.
REQ-032 Reset values SHALL be: ack=0, memwrite=0, busy=0, adr=0, memOut=0, rdata=0, last_grant=NUM_MASTERS-1.

Configuration
REQ-033 Macro ARB_FIXED_PRIORITY_EN, when defined, SHALL replace round-robin with fixed priority: the lowest requesting index always wins, and last_grant is unused.
REQ-034 Without ARB_FIXED_PRIORITY_EN, round-robin per REQ-025 SHALL apply.

Verification
REQ-035 Single read: NUM_MASTERS=2, READ_LAT=1, master 0 reads 0x0010 with memory holding 0xBEEF -> ack[0] exactly 3 cycles after the sample, rdata=0xBEEF.
REQ-036 Single write: master 1 writes 0x1234 to 0x0020 -> memwrite high exactly one cycle with adr=0x0020, memOut=0x1234; ack[1] 2 cycles after the sample.
REQ-037 Contention: req=2'b11 held continuously -> grants alternate 0,1,0,1 after reset (round-robin); with ARB_FIXED_PRIORITY_EN, master 0 is granted every time.
REQ-038 READ_LAT=3 read -> ack 5 cycles after the sample, and rdata equals memdata as presented 3 cycles after ISSUE.
REQ-039 Reset asserted during WAIT -> memwrite=0, busy=0, and no ack; the next request completes normally.
REQ-040 Requester drops req during ISSUE -> its ack still pulses once and no second transaction starts.
